// File: rtl/tio_wb_master.sv
// Wishbone initiator that turns a single command handshake into one classic
// wishbone transfer. It retries on rty, aborts on err, timeout or retry
// exhaustion, and returns the result on a response handshake.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready_o high
// STROBE | cyc/stb asserted, sampling ack/err/rty and counting timeout
// GAP    | one idle cycle between a rty and the next strobe
// RESP   | response presented until rsp_ready_i
module tio_wb_master #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [11:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [11:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, STROBE, GAP, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RTY_MAX = 4'(MAX_RETRY);

  localparam logic [1:0] ST_ACK = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TO  = 2'b10;
  localparam logic [1:0] ST_RTY = 2'b11;

  state_t      state;
  logic [15:0] to_cnt;
  logic [3:0]  rty_cnt;

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // Transfer sequencer; bus and response outputs are registered with the state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state        <= IDLE;
      to_cnt       <= '0;
      rty_cnt      <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= ST_ACK;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wb_we_o  <= cmd_we_i;
            wb_adr_o <= cmd_adr_i;
            wb_dat_o <= cmd_dat_i;
            wb_sel_o <= cmd_sel_i;
            rty_cnt  <= '0;
            to_cnt   <= '0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= STROBE;
          end
        end
        STROBE: begin
          if (wb_ack_i) begin
            rsp_dat_o    <= wb_we_o ? 32'h0 : wb_dat_i;
            rsp_status_o <= ST_ACK;
            rsp_valid_o  <= 1'b1;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            state        <= RESP;
          end else if (wb_err_i) begin
            rsp_dat_o    <= '0;
            rsp_status_o <= ST_ERR;
            rsp_valid_o  <= 1'b1;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            state        <= RESP;
          end else if (wb_rty_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (rty_cnt < RTY_MAX) begin
              rty_cnt <= rty_cnt + 4'd1;
              state   <= GAP;
            end else begin
              rsp_dat_o    <= '0;
              rsp_status_o <= ST_RTY;
              rsp_valid_o  <= 1'b1;
              state        <= RESP;
            end
          end else if (to_cnt == TO_LAST) begin
            rsp_dat_o    <= '0;
            rsp_status_o <= ST_TO;
            rsp_valid_o  <= 1'b1;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            state        <= RESP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        GAP: begin
          // Each strobe attempt gets a fresh timeout budget.
          to_cnt   <= '0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          state    <= STROBE;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tio_wb_master.sv
// Directed bench for tio_wb_master (TIMEOUT=4, MAX_RETRY=2). Stimulus pushes
// the expected response into a queue; a monitor pops it on each response
// handshake. A small target process answers strobes according to a mode.
module tb_tio_wb_master;

  localparam int M_NONE     = 0;
  localparam int M_ACK      = 1;
  localparam int M_RTY      = 2;
  localparam int M_RTY_ACK  = 3;
  localparam int M_RTY_NONE = 4;
  localparam int M_ACKERR   = 5;
  localparam int M_ERR      = 6;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [11:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        wb_cyc, wb_stb, wb_we;
  logic [11:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err, wb_rty;
  logic [31:0] wb_dat_i;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  int          tgt_mode = M_NONE;
  int          tgt_ackn = 1;
  logic [31:0] tgt_rdata = '0;

  tio_wb_master #(.TIMEOUT(4), .MAX_RETRY(2)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty), .wb_dat_i(wb_dat_i),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Wishbone target: terminations outside a strobe are asserted on purpose
  // so that any sampling outside STROBE shows up as a wrong result.
  initial begin
    int stb_idx = 0;
    int cyc_n = 0;
    logic prev_cyc = 1'b0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
      wb_dat_i = tgt_rdata;
      if (wb_cyc) begin
        if (!prev_cyc) begin
          stb_idx++;
          cyc_n = 1;
        end else begin
          cyc_n++;
        end
        case (tgt_mode)
          M_ACK:      wb_ack = (cyc_n == tgt_ackn);
          M_RTY:      wb_rty = 1'b1;
          M_RTY_ACK:  if (stb_idx == 1) wb_rty = 1'b1; else wb_ack = 1'b1;
          M_RTY_NONE: wb_rty = (stb_idx == 1);
          M_ACKERR:   begin wb_ack = 1'b1; wb_err = 1'b1; end
          M_ERR:      wb_err = 1'b1;
          default:    ;
        endcase
      end else if (rst_n) begin
        wb_ack = 1'b1; wb_err = 1'b1; wb_rty = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        if (cmd_ready) stb_idx = 0;
      end
      prev_cyc = wb_cyc;
    end
  end

  // Scoreboard monitor: compare each response as its handshake completes.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("rsp_dat", rsp_dat, e[33:2]);
        chk("rsp_status", 32'(rsp_status), 32'(e[1:0]));
      end
    end
  end

  task automatic run_cmd(input string tag, input logic we, input logic [11:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input int mode, input int ackn, input logic [31:0] rdata,
                         input logic [31:0] exp_dat, input logic [1:0] exp_st,
                         input int exp_lat, input int exp_cyc, input int exp_stb,
                         input bit hold);
    int lat, ncyc, nstb;
    logic prev;
    bit bad;
    @(posedge clk); #1;
    tgt_mode = mode; tgt_ackn = ackn; tgt_rdata = rdata;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    rsp_ready = !hold;
    @(negedge clk);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    exp_q.push_back({exp_dat, exp_st});
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;
    lat = 0; ncyc = 0; nstb = 0; prev = 1'b0; bad = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      if (wb_cyc) begin
        ncyc++;
        if (!prev) nstb++;
      end
      if (wb_stb !== wb_cyc || wb_adr !== adr || wb_we !== we ||
          wb_dat_o !== dat || wb_sel !== sel || busy !== 1'b1) bad = 1'b1;
      prev = wb_cyc;
      if (lat > 60) break;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_cyc_cycles"}, ncyc, exp_cyc);
    chk({tag, "_strobes"}, nstb, exp_stb);
    chk({tag, "_bus_fields"}, 32'(bad), 32'h0);
    if (hold) begin
      bad = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_dat !== exp_dat || rsp_status !== exp_st ||
            cmd_ready !== 1'b0 || wb_cyc !== 1'b0) bad = 1'b1;
      end
      chk({tag, "_hold_stable"}, 32'(bad), 32'h0);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc), 32'h0);
    chk("rst_stb", 32'(wb_stb), 32'h0);
    chk("rst_adr", 32'(wb_adr), 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp", {rsp_dat[29:0], rsp_status}, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'h1);

    //       tag       we    adr     dat           sel   mode        n  rdata         exp_dat       st     lat cyc stb hold
    run_cmd("rd0",    1'b0, 12'h000, 32'h0,        4'hF, M_ACK,      2, 32'h5446494F, 32'h5446494F, 2'b00, 3, 2, 1, 0);
    run_cmd("wr8",    1'b1, 12'h008, 32'h80000000, 4'hF, M_ACK,      1, 32'h13579BDF, 32'h0,        2'b00, 2, 1, 1, 0);
    run_cmd("tmo",    1'b0, 12'h010, 32'h0,        4'h3, M_NONE,     1, 32'h11111111, 32'h0,        2'b10, 5, 4, 1, 0);
    run_cmd("rtyx",   1'b0, 12'h020, 32'h0,        4'hF, M_RTY,      1, 32'h22222222, 32'h0,        2'b11, 6, 3, 3, 0);
    run_cmd("rtyack", 1'b0, 12'h024, 32'h0,        4'hF, M_RTY_ACK,  1, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 4, 2, 2, 0);
    run_cmd("rtytmo", 1'b1, 12'h028, 32'h0BADF00D, 4'h1, M_RTY_NONE, 1, 32'h33333333, 32'h0,        2'b10, 7, 5, 2, 0);
    run_cmd("ackerr", 1'b0, 12'h030, 32'h0,        4'hF, M_ACKERR,   1, 32'h12345678, 32'h12345678, 2'b00, 2, 1, 1, 0);
    run_cmd("err",    1'b1, 12'h034, 32'h5A5A5A5A, 4'hC, M_ERR,      1, 32'h44444444, 32'h0,        2'b01, 2, 1, 1, 0);
    run_cmd("hold",   1'b0, 12'h040, 32'h0,        4'hF, M_ACK,      1, 32'hA5A55A5A, 32'hA5A55A5A, 2'b00, 2, 1, 1, 1);

    // Reset pulse during STROBE: transfer dropped with no response.
    @(posedge clk); #1;
    tgt_mode = M_NONE;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 12'h050; cmd_dat = 32'hFFFF0000; cmd_sel = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_pre_cyc", 32'(wb_cyc), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(wb_cyc), 32'h0);
    chk("mid_rst_stb", 32'(wb_stb), 32'h0);
    chk("mid_rst_adr", 32'(wb_adr), 32'h0);
    repeat (2) @(negedge clk);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_after", 32'(cmd_ready), 32'h1);
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);

    run_cmd("after",  1'b0, 12'h0FC, 32'h0,        4'hF, M_ACK,      3, 32'h0F0F0F0F, 32'h0F0F0F0F, 2'b00, 4, 3, 1, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tio_wb_master.md
TIO_WB_MASTER -- requirements
Module: tio_wb_master

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 255, meaning the number of wishbone cycles to wait for a termination before abort (range 1..65535).
REQ-002 The module SHALL have parameter MAX_RETRY, default 3, meaning the number of rty terminations tolerated before abort (range 0..15).
REQ-003 The module SHALL have port wb_clk_i  in  1  sole clock, with all logic on its rising edge.
REQ-004 The module SHALL have port wb_rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have ports cmd_valid_i in 1, cmd_ready_o out 1: command handshake.
REQ-006 The module SHALL have ports cmd_we_i in 1, cmd_adr_i in 12, cmd_dat_i in 32, cmd_sel_i in 4: command write flag, byte address, write data and byte lanes.
REQ-007 The module SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1: response handshake.
REQ-008 The module SHALL have ports rsp_dat_o out 32 and rsp_status_o out 2: read data and status (00 ack, 01 err, 10 timeout, 11 retry exhausted).
REQ-009 The module SHALL have wishbone initiator ports wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_adr_o out 12; wb_dat_o out 32; wb_sel_o out 4; wb_ack_i, wb_err_i, wb_rty_i in 1; wb_dat_i in 32.
REQ-010 The module SHALL have port busy_o  out 1, high whenever the state is not IDLE.

Function
REQ-011 The module SHALL implement the states IDLE, STROBE, GAP and RESP.
REQ-012 cmd_ready_o SHALL be combinationally high only in IDLE; a command is accepted on a cycle where cmd_valid_i && cmd_ready_o.
REQ-013 On acceptance, the module SHALL register the command fields into wb_we_o/wb_adr_o/wb_dat_o/wb_sel_o, clear the retry count, clear the timeout count, and enter STROBE.
REQ-014 wb_cyc_o and wb_stb_o SHALL be registered, and SHALL be high exactly while in STROBE.
REQ-015 wb_adr_o, wb_we_o, wb_dat_o and wb_sel_o SHALL hold stable from acceptance until the next acceptance.
REQ-016 In STROBE, terminations SHALL be sampled each cycle with priority ack > err > rty > timeout.
REQ-017 On ack in STROBE: rsp_dat_o SHALL take wb_dat_i if the transfer is a read, or 0 if it is a write; rsp_status_o SHALL be 00; the next state SHALL be RESP.
REQ-018 On err in STROBE: rsp_dat_o SHALL be 0, rsp_status_o SHALL be 01, and the next state SHALL be RESP.
REQ-019 On rty in STROBE with retry count < MAX_RETRY: the retry count SHALL increment and the next state SHALL be GAP.
REQ-020 On rty in STROBE with retry count == MAX_RETRY: rsp_dat_o SHALL be 0, rsp_status_o SHALL be 11, and the next state SHALL be RESP.
REQ-021 The timeout count SHALL increment each STROBE cycle with no termination; when it equals TIMEOUT-1 with no termination in that cycle, rsp_dat_o SHALL be 0, rsp_status_o SHALL be 10, and the next state SHALL be RESP, so that STROBE lasts exactly TIMEOUT cycles.
REQ-022 GAP SHALL last exactly one cycle with cyc/stb low, clear the timeout count, and then return to STROBE.
REQ-023 Within a single command, the timeout count SHALL restart on every STROBE entry and SHALL NOT accumulate across retries.
REQ-024 rsp_valid_o SHALL be high exactly while in RESP, and rsp_dat_o/rsp_status_o SHALL be stable while rsp_valid_o is high.
REQ-025 RESP SHALL transition to IDLE on rsp_ready_i, and SHALL hold indefinitely without it.
REQ-026 cyc/stb SHALL be low in the cycle after any termination is sampled (no back-to-back strobes); the minimum command-to-response latency is 2 cycles (accept, STROBE with ack, RESP).
REQ-027 wb_ack_i, wb_err_i and wb_rty_i SHALL be ignored outside STROBE.
REQ-028 Command inputs SHALL be ignored outside IDLE.

Reset
REQ-029 While wb_rst_n_i is low, the module SHALL asynchronously force: state IDLE; wb_cyc_o=0; wb_stb_o=0; wb_we_o=0; wb_adr_o=0; wb_dat_o=0; wb_sel_o=0; rsp_valid_o=0; rsp_dat_o=0; rsp_status_o=00; busy_o=0; retry and timeout counts 0.
REQ-030 Reset asserted mid-transfer SHALL drop cyc/stb immediately and discard the transfer with no response.
REQ-031 After reset release, cmd_ready_o SHALL be high in the first clock cycle.

Verification
REQ-032 The bench SHALL cover: read adr 0x000, target acks in the 2nd STROBE cycle with 0x5446494F -> rsp_dat_o=0x5446494F, status 00, rsp_valid_o asserted 3 cycles after acceptance.
REQ-033 The bench SHALL cover: write adr 0x008, dat 0x80000000, sel 0xF, ack in the 1st cycle -> wb_we_o=1 during strobe, rsp_dat_o=0, status 00.
REQ-034 The bench SHALL cover: TIMEOUT=4 with no termination -> cyc high exactly 4 cycles, then status 10.
REQ-035 The bench SHALL cover: MAX_RETRY=2 with target rty on every strobe -> 3 strobes separated by one-cycle gaps, then status 11; a variant where ack comes on the 2nd strobe gives status 00.
REQ-036 The bench SHALL cover: simultaneous ack and err -> status 00; and rsp_ready_i held low 10 cycles -> response stable and cmd_ready_o low throughout.
REQ-037 The bench SHALL cover: wb_rst_n_i pulsed low during STROBE -> cyc/stb drop in the same cycle, no rsp_valid_o, and cmd_ready_o high after release.
